// File: rtl/ds_sb_stage.sv
// Decode stage: latches fs instruction, reads regfile, interlocks RAW hazards via a
// per-register pending-write scoreboard. Define SB_WB_BYPASS_EN to issue in the writeback cycle.
module ds_sb_stage #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STALL_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_to_ds_valid,
    input  logic [32+XLEN-1:0]     fs_to_ds_bus,
    output logic                   ds_allowin,
    input  logic                   es_allowin,
    output logic                   ds_to_es_valid,
    output logic [3*XLEN+38-1:0]   ds_to_es_bus,
    input  logic                   ds_flush,
    input  logic [6+XLEN-1:0]      ws_to_rf_bus,
    output logic [STALL_W-1:0]     stall_cnt
);

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                 ds_valid;
    logic [32+XLEN-1:0]   ds_bus;
    logic [31:0]          inst;
    logic [XLEN-1:0]      pc;
    logic [4:0]           rd, rs1, rs2;
    logic                 rd_used, rs1_used, rs2_used, rd_we;

    logic                 ws_we, wr_en;
    logic [4:0]           ws_waddr;
    logic [XLEN-1:0]      ws_wdata;

    logic [CNT_W-1:0]     cnt [32];
    logic [XLEN-1:0]      rf  [32];
    logic [31:0]          sb_inc, sb_dec;
    logic [XLEN-1:0]      rs1_data, rs2_data;
    logic                 bypass1, bypass2, haz1, haz2, stall, ds_ready_go, fire;

    assign inst = ds_bus[XLEN+31:XLEN];
    assign pc   = ds_bus[XLEN-1:0];
    assign rd   = inst[11:7];
    assign rs1  = inst[19:15];
    assign rs2  = inst[24:20];

    assign ws_we    = ws_to_rf_bus[XLEN+5];
    assign ws_waddr = ws_to_rf_bus[XLEN+4:XLEN];
    assign ws_wdata = ws_to_rf_bus[XLEN-1:0];
    assign wr_en    = ws_we && (ws_waddr != 5'd0);

    // Register usage by opcode
    always_comb begin
        rd_used  = 1'b0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (inst[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: rd_used = 1'b1;
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
            end
            OPC_OP, OPC_OP32: begin
                rd_used  = 1'b1;
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

    assign rd_we = rd_used && (rd != 5'd0);

`ifdef SB_WB_BYPASS_EN
    assign bypass1 = ws_we && (ws_waddr == rs1) && (cnt[rs1] == CNT_W'(1));
    assign bypass2 = ws_we && (ws_waddr == rs2) && (cnt[rs2] == CNT_W'(1));
`else
    assign bypass1 = 1'b0;
    assign bypass2 = 1'b0;
`endif

    // Write-through read; covers the bypass data path as well
    always_comb begin
        rs1_data = rf[rs1];
        rs2_data = rf[rs2];
        if (wr_en && (ws_waddr == rs1)) rs1_data = ws_wdata;
        if (wr_en && (ws_waddr == rs2)) rs2_data = ws_wdata;
        if (rs1 == 5'd0) rs1_data = '0;
        if (rs2 == 5'd0) rs2_data = '0;
    end

    assign haz1 = rs1_used && (rs1 != 5'd0) && (cnt[rs1] != '0) && !bypass1;
    assign haz2 = rs2_used && (rs2 != 5'd0) && (cnt[rs2] != '0) && !bypass2;
    assign stall = ds_valid && (haz1 || haz2 || (rd_we && (cnt[rd] == CNT_MAX)));

    assign ds_ready_go    = !stall;
    assign ds_allowin     = !ds_valid || (ds_ready_go && es_allowin);
    assign ds_to_es_valid = ds_valid && ds_ready_go && !ds_flush;
    assign fire           = ds_to_es_valid && es_allowin;
    assign ds_to_es_bus   = {pc, inst, rs1_data, rs2_data, rd, rd_we};

    always_ff @(posedge clk) begin
        if (reset) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid && !ds_flush;
        end else if (ds_flush) begin
            ds_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ds_allowin && fs_to_ds_valid) ds_bus <= fs_to_ds_bus;
    end

    // Scoreboard deltas; x0 never gets an inc or dec
    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        if (fire && rd_we) sb_inc[rd] = 1'b1;
        if (wr_en && (cnt[ws_waddr] != '0)) sb_dec[ws_waddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else begin
                case ({sb_inc[i], sb_dec[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) rf[ws_waddr] <= ws_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && !ds_flush) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule
